// File: rtl/inv_sub_bytes_serial_if.sv
// Handshake and data bundle between inv_shift_rows, inv_sub_bytes_serial and the key-add stage.
interface inv_sub_bytes_serial_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] sb_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] sb_out;
    logic         busy;

    modport master (
        output in_valid,
        output sb_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sb_out,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  sb_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sb_out,
        output busy
    );
endinterface

// File: rtl/inv_sub_bytes_serial.sv
// Serial AES InvSubBytes: LANES shared S-box lookups per cycle over a 128-bit state word.
// Optional INV_SUB_FWD_EN adds a 'mode' port selecting the forward S-box for encryption reuse.
module inv_sub_bytes_serial #(
    parameter int LANES = 4
) (
    input  logic clk,
    input  logic rst_n,
`ifdef INV_SUB_FWD_EN
    input  logic mode,
`endif
    inv_sub_bytes_serial_if.slave bus
);

    localparam int NCYC = 16 / LANES;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_sub_bytes_serial: LANES must be 1, 2, 4, 8 or 16");
    end

    // Entry b sits at bits [8*(255-b) +: 8], so the select base is simply {~b, 3'b000}.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

`ifdef INV_SUB_FWD_EN
    localparam logic [2047:0] FWD_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic mode_q;

    function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic fwd);
        return fwd ? FWD_SBOX[{~b, 3'b000} +: 8] : INV_SBOX[{~b, 3'b000} +: 8];
    endfunction
`else
    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b000} +: 8];
    endfunction
`endif

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic   [3:0]   cnt_q;
    logic   [127:0] work_q;
    logic   [127:0] work_next;
    logic   [127:0] out_q;
    logic           load;
    logic           sub_en;
    logic           last;
    logic           in_ready_w;
    logic           out_valid_w;
    logic           busy_w;

    assign last = (cnt_q == 4'(NCYC - 1));

    // Replace this cycle's LANES bytes in place; all other bytes pass through unchanged.
    always_comb begin
        logic [3:0] bidx;
        bidx      = '0;
        work_next = work_q;
        for (int l = 0; l < LANES; l++) begin
            bidx = 4'(int'(cnt_q) * LANES + l);
`ifdef INV_SUB_FWD_EN
            work_next[{bidx, 3'b000} +: 8] = sub_byte(work_q[{bidx, 3'b000} +: 8], mode_q);
`else
            work_next[{bidx, 3'b000} +: 8] = sub_byte(work_q[{bidx, 3'b000} +: 8]);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        sub_en      = 1'b0;
        in_ready_w  = 1'b0;
        out_valid_w = 1'b0;
        busy_w      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready_w = 1'b1;
                busy_w     = 1'b0;
                if (bus.in_valid) begin
                    load    = 1'b1;
                    state_d = SUB;
                end
            end
            SUB: begin
                sub_en = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_w = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_w  = 1'b0;
            end
        endcase
    end

    // The output register only loads on the final substitution cycle so it stays frozen under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 4'd0;
            work_q <= 128'h0;
            out_q  <= 128'h0;
`ifdef INV_SUB_FWD_EN
            mode_q <= 1'b0;
`endif
        end else begin
            if (load) begin
                work_q <= bus.sb_in;
                cnt_q  <= 4'd0;
`ifdef INV_SUB_FWD_EN
                mode_q <= mode;
`endif
            end else if (sub_en) begin
                work_q <= work_next;
                cnt_q  <= last ? 4'd0 : cnt_q + 4'd1;
            end
            if (sub_en && last) begin
                out_q <= work_next;
            end
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.busy      = busy_w;
    assign bus.sb_out    = out_q;

endmodule

// File: tb/tb_inv_sub_bytes_serial.sv
// Self-checking bench for inv_sub_bytes_serial: vector table, corner sequences and a LANES sweep
// against S-boxes rebuilt from GF(2^8) arithmetic.
module tb_inv_sub_bytes_serial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sw_rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   tables_ready = 1'b0;

    logic [7:0] fwd_tbl [256];
    logic [7:0] inv_tbl [256];

    always #5 clk = ~clk;

    inv_sub_bytes_serial_if bus();

`ifdef INV_SUB_FWD_EN
    logic mode_drv = 1'b0;
    bit   flip_mode = 1'b0;
`endif

    inv_sub_bytes_serial #(.LANES(4)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
`ifdef INV_SUB_FWD_EN
        .mode (mode_drv),
`endif
        .bus  (bus)
    );

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        for (int x = 1; x < 256; x++) begin
            if (gmul(a, 8'(x)) == 8'h01) return 8'(x);
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    // S-box = affine transform of the multiplicative inverse; the inverse table is its permutation inverse.
    initial begin
        logic [7:0] b;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            b = ginv(8'(x));
            s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
            fwd_tbl[x] = s;
            inv_tbl[s] = 8'(x);
        end
        tables_ready = 1'b1;
    end

    function automatic logic [127:0] ref_block(input logic [127:0] w, input bit fwd);
        logic [127:0] r = '0;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = fwd ? fwd_tbl[w[8*i +: 8]] : inv_tbl[w[8*i +: 8]];
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge where out_valid is first seen high.
    task automatic applyStimulus(input logic [127:0] din, output int lat, output int busy_low,
                                 output logic [127:0] res);
        int wd = 0;
        lat = 0;
        busy_low = 0;
        while (!bus.in_ready && wd < 50) begin
            @(negedge clk);
            wd++;
        end
        bus.sb_in    = din;
        bus.in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
`ifdef INV_SUB_FWD_EN
        if (flip_mode) mode_drv = ~mode_drv;
`endif
        while (!bus.out_valid && lat < 40) begin
            if (!bus.busy) busy_low++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!bus.busy) busy_low++;
        res = bus.sb_out;
    endtask

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
        string        name;
    } vec_t;

    vec_t vecs [4];

    genvar g;
    for (g = 0; g < 4; g++) begin : g_sweep
        localparam int LP = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
        bit done_flag = 1'b0;

        inv_sub_bytes_serial_if sbus();

        inv_sub_bytes_serial #(.LANES(LP)) u_sw (
            .clk  (clk),
            .rst_n(sw_rst_n),
`ifdef INV_SUB_FWD_EN
            .mode (1'b0),
`endif
            .bus  (sbus)
        );

        initial begin
            logic [127:0] din;
            int lat;
            int wd;
            sbus.in_valid  = 1'b0;
            sbus.sb_in     = '0;
            sbus.out_ready = 1'b1;
            wait (tables_ready);
            while (!sw_rst_n) @(negedge clk);
            for (int n = 0; n < 200; n++) begin
                @(negedge clk);
                wd = 0;
                while (!sbus.in_ready && wd < 50) begin
                    @(negedge clk);
                    wd++;
                end
                din = {$urandom, $urandom, $urandom, $urandom};
                sbus.sb_in    = din;
                sbus.in_valid = 1'b1;
                @(posedge clk);
                lat = 1;
                @(negedge clk);
                sbus.in_valid = 1'b0;
                while (!sbus.out_valid && lat < 40) begin
                    @(posedge clk);
                    lat++;
                    @(negedge clk);
                end
                checkOutput($sformatf("sweep L%0d latency", LP), 128'(lat), 128'(16 / LP + 1));
                checkOutput($sformatf("sweep L%0d result", LP), sbus.sb_out, ref_block(din, 1'b0));
            end
            done_flag = 1'b1;
        end
    end

    initial begin
        sw_rst_n = 1'b0;
        #23 sw_rst_n = 1'b1;
    end

    initial begin
        int lat;
        int busy_low;
        int stall;
        logic [127:0] res;
        logic [127:0] wa;
        logic [127:0] wb;
        logic [127:0] wd;
        bit all_done;

        vecs[0] = '{128'h0, {16{8'h52}}, "all zero"};
        vecs[1] = '{{16{8'h63}}, 128'h0, "all 63"};
        vecs[2] = '{{4{32'h0001ff7c}}, {4{32'h52097d01}}, "7c ff 01 00"};
        vecs[3] = '{128'h0f0e0d0c0b0a09080706050403020100, 128'hfbd7f3819ea340bf38a53630d56a0952, "ramp"};

        bus.in_valid  = 1'b0;
        bus.sb_in     = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        wait (tables_ready);
        repeat (3) @(negedge clk);
        checkOutput("reset out_valid", 128'(bus.out_valid), 128'd0);
        checkOutput("reset busy", 128'(bus.busy), 128'd0);
        checkOutput("reset sb_out", bus.sb_out, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("in_ready after reset", 128'(bus.in_ready), 128'd1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].din, lat, busy_low, res);
            checkOutput({vecs[i].name, " latency"}, 128'(lat), 128'd5);
            checkOutput({vecs[i].name, " result"}, res, vecs[i].dout);
            checkOutput({vecs[i].name, " busy"}, 128'(busy_low), 128'd0);
            @(negedge clk);
            checkOutput({vecs[i].name, " out_valid drop"}, 128'(bus.out_valid), 128'd0);
            checkOutput({vecs[i].name, " sb_out hold"}, bus.sb_out, vecs[i].dout);
        end

        $display("[TB] backpressure sequence");
        wa = {$urandom, $urandom, $urandom, $urandom};
        wb = {$urandom, $urandom, $urandom, $urandom};
        bus.out_ready = 1'b0;
        applyStimulus(wa, lat, busy_low, res);
        for (int c = 0; c < 10; c++) begin
            checkOutput("stall sb_out", bus.sb_out, ref_block(wa, 1'b0));
            checkOutput("stall out_valid", 128'(bus.out_valid), 128'd1);
            checkOutput("stall in_ready", 128'(bus.in_ready), 128'd0);
            bus.in_valid = (c == 3);
            bus.sb_in    = wb;
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("release out_valid", 128'(bus.out_valid), 128'd0);
        checkOutput("release in_ready", 128'(bus.in_ready), 128'd1);
        checkOutput("release sb_out", bus.sb_out, ref_block(wa, 1'b0));
        @(negedge clk);
        checkOutput("stalled pulse ignored", 128'(bus.busy), 128'd0);
        applyStimulus(wb, lat, busy_low, res);
        checkOutput("after stall result", res, ref_block(wb, 1'b0));
        @(negedge clk);

        $display("[TB] reset during SUB");
        wd = {$urandom, $urandom, $urandom, $urandom};
        bus.sb_in    = {$urandom, $urandom, $urandom, $urandom};
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("sb_out frozen in SUB", bus.sb_out, ref_block(wb, 1'b0));
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async reset sb_out", bus.sb_out, 128'h0);
        checkOutput("async reset busy", 128'(bus.busy), 128'd0);
        checkOutput("async reset out_valid", 128'(bus.out_valid), 128'd0);
        checkOutput("async reset in_ready", 128'(bus.in_ready), 128'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("no resume after reset", 128'(bus.busy), 128'd0);
        applyStimulus(wd, lat, busy_low, res);
        checkOutput("fresh block latency", 128'(lat), 128'd5);
        checkOutput("fresh block result", res, ref_block(wd, 1'b0));
        @(negedge clk);

        $display("[TB] random blocks with stalls");
        for (int n = 0; n < 40; n++) begin
            wa = {$urandom, $urandom, $urandom, $urandom};
            stall = $urandom_range(0, 3);
            bus.out_ready = (stall == 0);
            applyStimulus(wa, lat, busy_low, res);
            checkOutput("random latency", 128'(lat), 128'd5);
            checkOutput("random result", res, ref_block(wa, 1'b0));
            repeat (stall) @(negedge clk);
            checkOutput("random hold", bus.sb_out, ref_block(wa, 1'b0));
            bus.out_ready = 1'b1;
            @(negedge clk);
        end

`ifdef INV_SUB_FWD_EN
        $display("[TB] forward mode");
        mode_drv = 1'b1;
        applyStimulus({16{8'h53}}, lat, busy_low, res);
        checkOutput("fwd 53", res, {16{8'hed}});
        @(negedge clk);
        applyStimulus(128'h0, lat, busy_low, res);
        checkOutput("fwd zero", res, {16{8'h63}});
        @(negedge clk);
        wa = {$urandom, $urandom, $urandom, $urandom};
        flip_mode = 1'b1;
        applyStimulus(wa, lat, busy_low, res);
        flip_mode = 1'b0;
        checkOutput("mode toggle mid-block", res, ref_block(wa, 1'b1));
        @(negedge clk);
        mode_drv = 1'b0;
        applyStimulus(wa, lat, busy_low, res);
        checkOutput("back to inverse", res, ref_block(wa, 1'b0));
        @(negedge clk);
`endif

        all_done = 1'b0;
        for (int k = 0; k < 20000 && !all_done; k++) begin
            @(negedge clk);
            all_done = g_sweep[0].done_flag && g_sweep[1].done_flag &&
                       g_sweep[2].done_flag && g_sweep[3].done_flag;
        end
        checkOutput("sweep finished", 128'(all_done), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
